// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests,
// buffers responses with their PCs and hands them to decode. Optional perf counters: IF_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PW = $clog2(BUF_DEPTH);
  typedef logic [PW:0] ptr_t;
  typedef enum logic {RUN, DRAIN} state_t;

  logic [31:0]          r_entryPc    [BUF_DEPTH];
  logic [31:0]          r_entryInstr [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] r_filled;
  ptr_t                 r_head;
  ptr_t                 r_tail;
  ptr_t                 r_fill;
  ptr_t                 r_drop;
  logic [31:0]          r_fetchPc;
  state_t               r_state;

  state_t               w_stateNext;
  ptr_t                 w_dropNext;
  ptr_t                 w_alloc;
  ptr_t                 w_unfilled;
  logic [PW+1:0]        w_credit;
  logic                 w_full;
  logic                 w_dropping;
  logic                 w_reqFire;
  logic                 w_deliver;
  logic                 w_respFill;
  logic [PW-1:0]        w_headIdx;
  logic [PW-1:0]        w_tailIdx;
  logic [PW-1:0]        w_fillIdx;

  assign w_headIdx  = r_head[PW-1:0];
  assign w_tailIdx  = r_tail[PW-1:0];
  assign w_fillIdx  = r_fill[PW-1:0];
  assign w_alloc    = r_tail - r_head;
  assign w_unfilled = r_tail - r_fill;
  assign w_credit   = {1'b0, w_alloc} + {1'b0, r_drop};
  assign w_full     = (w_headIdx == w_tailIdx) && (r_head[PW] != r_tail[PW]);

  assign w_reqFire  = imem_req_valid && imem_req_ready;
  assign w_deliver  = id_valid && id_ready;
  assign w_respFill = imem_resp_valid && !w_dropping;

  // Stale-response counter and the RUN/DRAIN state it implies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_drop  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_drop  <= w_dropNext;
    end
  end

  // A redirect turns every allocated-but-unfilled slot into a pending drop;
  // a response arriving in that same cycle is itself one of the stale ones.
  always_comb begin
    w_dropNext = r_drop;
    if (redirect_valid)
      w_dropNext = r_drop + w_unfilled - {{PW{1'b0}}, imem_resp_valid};
    else if (imem_resp_valid && w_dropping)
      w_dropNext = r_drop - {{PW{1'b0}}, 1'b1};
    w_stateNext = (w_dropNext != '0) ? DRAIN : RUN;
  end

  always_comb begin
    w_dropping     = (r_state == DRAIN);
    imem_req_valid = reset_n && !redirect_valid && !w_full &&
                     (w_credit < (PW+2)'(BUF_DEPTH));
    id_valid       = r_filled[w_headIdx] && !redirect_valid;
  end

  assign imem_req_addr = r_fetchPc;
  assign id_instr      = r_entryInstr[w_headIdx];
  assign id_pc         = r_entryPc[w_headIdx];

  // Circular buffer: allocate at tail, fill in order at fill pointer, retire at head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_fill   <= '0;
      r_filled <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_entryPc[i]    <= '0;
        r_entryInstr[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_fill   <= '0;
      r_filled <= '0;
    end else begin
      if (w_reqFire) begin
        r_entryPc[w_tailIdx] <= r_fetchPc;
        r_filled[w_tailIdx]  <= 1'b0;
        r_tail               <= r_tail + 1'b1;
      end
      if (w_respFill) begin
        r_entryInstr[w_fillIdx] <= imem_resp_data;
        r_filled[w_fillIdx]     <= 1'b1;
        r_fill                  <= r_fill + 1'b1;
      end
      if (w_deliver) begin
        r_filled[w_headIdx] <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_fetchPc <= RESET_PC;
    else if (redirect_valid)
      r_fetchPc <= {redirect_pc[31:2], 2'b00};
    else if (w_reqFire)
      r_fetchPc <= r_fetchPc + 32'd4;
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_reqFire)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a table of per-cycle vectors for the reset-release stream,
// then hand-written stall, redirect, wrap and (with IF_PERF_CNT_EN) counter sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  typedef struct {
    logic        idReady;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expIdValid;
    logic [31:0] expIdPc;
  } vector_t;

  memReq_t     pendQ[$];
  logic [31:0] delivPc[$];
  logic [31:0] delivInstr[$];
  int          cycle;
  int          memLatency = 1;
  int          acceptCnt;
  int          redirectCnt;
  int          checks = 0;
  int          errors = 0;
  vector_t     vecs[7];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h0100_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
    id_ready       = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  // Records this cycle's handshakes, crosses the edge, then drives the memory response for the new cycle.
  task automatic stepCycle();
    if (imem_req_valid && imem_req_ready) begin
      pendQ.push_back('{addr: imem_req_addr, due: cycle + memLatency});
      acceptCnt++;
    end
    if (id_valid && id_ready) begin
      delivPc.push_back(id_pc);
      delivInstr.push_back(id_instr);
    end
    if (redirect_valid)
      redirectCnt++;
    @(posedge clk);
    #1;
    cycle++;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (pendQ.size() > 0 && pendQ[0].due <= cycle) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memWord(pendQ[0].addr);
      void'(pendQ.pop_front());
    end
  endtask

  task automatic doReset();
    reset_n         = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    id_ready        = 1'b0;
    #1;
    pendQ.delete();
    delivPc.delete();
    delivInstr.delete();
    acceptCnt   = 0;
    redirectCnt = 0;
    checkOutput("rstReqValid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rstReqAddr", imem_req_addr, 32'h0);
    checkOutput("rstIdValid", {31'd0, id_valid}, 32'd0);
    checkOutput("rstIdInstr", id_instr, 32'h0);
    checkOutput("rstIdPc", id_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
    checkOutput("rstPerfFetch", perf_fetch_cnt, 32'd0);
    checkOutput("rstPerfFlush", perf_flush_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle   = 0;
  endtask

  initial begin
    // reset release with 1-cycle memory and decode always ready; credit of 2 allows
    // a new request only once the oldest entry retires
    vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    vecs[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    vecs[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};

    memLatency = 1;
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].idReady, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d.reqValid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].expReqValid});
      checkOutput($sformatf("vec%0d.reqAddr", i), imem_req_addr, vecs[i].expReqAddr);
      checkOutput($sformatf("vec%0d.idValid", i), {31'd0, id_valid}, {31'd0, vecs[i].expIdValid});
      if (vecs[i].expIdValid) begin
        checkOutput($sformatf("vec%0d.idPc", i), id_pc, vecs[i].expIdPc);
        checkOutput($sformatf("vec%0d.idInstr", i), id_instr, memWord(vecs[i].expIdPc));
      end
      stepCycle();
    end

    // decode stall: exactly two requests, output held on the 0x0 entry
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (c >= 2) begin
        checkOutput("stallIdValid", {31'd0, id_valid}, 32'd1);
        checkOutput("stallIdPc", id_pc, 32'h0);
        checkOutput("stallIdInstr", id_instr, memWord(32'h0));
      end
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stallReqValid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("stallAccepted", acceptCnt, 2);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      stepCycle();
    end
    checkOutput("stallDelivCount", {31'd0, delivPc.size() >= 3}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k < delivPc.size()) begin
        checkOutput($sformatf("stallOrderPc%0d", k), delivPc[k], 32'(4 * k));
        checkOutput($sformatf("stallOrderInstr%0d", k), delivInstr[k], memWord(32'(4 * k)));
      end
    end

    // 3-cycle memory, redirect while two responses are in flight
    memLatency = 3;
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("drainRedirReqValid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("drainInFlight", pendQ.size(), 2);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drainReqAddr", imem_req_addr, 32'h100);
    stepCycle();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      stepCycle();
    end
    checkOutput("drainDelivCount", {31'd0, delivPc.size() >= 2}, 32'd1);
    if (delivPc.size() >= 2) begin
      checkOutput("drainFirstPc", delivPc[0], 32'h100);
      checkOutput("drainFirstInstr", delivInstr[0], memWord(32'h100));
      checkOutput("drainSecondPc", delivPc[1], 32'h104);
    end

    // redirect coincident with a response and a ready decode stage
    memLatency = 1;
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("coinRespPresent", {31'd0, imem_resp_valid}, 32'd1);
    checkOutput("coinIdValid", {31'd0, id_valid}, 32'd0);
    checkOutput("coinReqValid", {31'd0, imem_req_valid}, 32'd0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("coinNextReqValid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("coinNextReqAddr", imem_req_addr, 32'h100);
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
    end
    checkOutput("coinDelivCount", {31'd0, delivPc.size() >= 1}, 32'd1);
    if (delivPc.size() >= 1)
      checkOutput("coinFirstPc", delivPc[0], 32'h100);

    // unaligned redirect target and fetch PC wrap at 2^32
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h103);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("alignReqValid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("alignReqAddr", imem_req_addr, 32'h100);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrapTopValid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("wrapTopAddr", imem_req_addr, 32'hFFFF_FFFC);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrapZeroValid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("wrapZeroAddr", imem_req_addr, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("wrapIdValid", {31'd0, id_valid}, 32'd1);
    checkOutput("wrapIdPc", id_pc, 32'hFFFF_FFFC);
    checkOutput("wrapIdInstr", id_instr, memWord(32'hFFFF_FFFC));

`ifdef IF_PERF_CNT_EN
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("perfFetch", perf_fetch_cnt, acceptCnt);
    checkOutput("perfFlush", perf_flush_cnt, 32'd2);
    stepCycle();
    #2;
    doReset();
`endif

    // asynchronous reset in the middle of a cycle clears state immediately
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    #2;
    doReset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
